left_shift_sequencer: RTL and testbench



---
 rtl/left_shift_sequencer.sv | 84 ++++++++
 tb/tb_left_shift_sequencer.sv | 128 ++++++++++++
 2 files changed

// File: rtl/left_shift_sequencer.sv
// Multi-cycle left shifter: latches an operand, then shifts it left one bit per clock.
// Arithmetic mode flags sign changes; logical mode flags any 1 shifted out.
module left_shift_sequencer #(
  parameter int WIDTH   = 16,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   in,
  input  logic [SHAMT_W-1:0] amount,
  input  logic               mode,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   out,
  output logic               overflow
);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t             r_state;
  state_t             w_next;
  logic [WIDTH-1:0]   r_out;
  logic [SHAMT_W-1:0] r_count;
  logic               r_mode;
  logic               r_ovf;
  logic               r_busy;
  logic               r_done;
  logic [SHAMT_W-1:0] w_n;
  logic               w_ovf_bit;

  // Amounts beyond WIDTH would only shift in more zeros, so clamp them.
  assign w_n = (amount > SHAMT_W'(WIDTH)) ? SHAMT_W'(WIDTH) : amount;

  // Evaluated on the pre-shift value of the working register.
  assign w_ovf_bit = r_mode ? r_out[WIDTH-1] : (r_out[WIDTH-1] ^ r_out[WIDTH-2]);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = (w_n != '0) ? S_SHIFT : S_DONE;
      S_SHIFT: if (r_count == SHAMT_W'(1)) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Flags are registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_out   <= '0;
      r_count <= '0;
      r_mode  <= 1'b0;
      r_ovf   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next != S_IDLE);
      r_done  <= (w_next == S_DONE);
      case (r_state)
        S_IDLE: if (start) begin
          r_out   <= in;
          r_ovf   <= 1'b0;
          r_mode  <= mode;
          r_count <= w_n;
        end
        S_SHIFT: begin
          r_out   <= {r_out[WIDTH-2:0], 1'b0};
          r_count <= r_count - SHAMT_W'(1);
          r_ovf   <= r_ovf | w_ovf_bit;
        end
        default: ;
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign out      = r_out;
  assign overflow = r_ovf;

endmodule

// File: tb/tb_left_shift_sequencer.sv
// Self-checking bench for left_shift_sequencer: directed plan cases plus random ops
// compared against a closed-form model of the shift result and overflow flag.
module tb_left_shift_sequencer;
  localparam int W  = 16;
  localparam int SW = 5;

  logic          clk = 1'b0;
  logic          reset, start, mode;
  logic [W-1:0]  in_d;
  logic [SW-1:0] amount;
  logic          busy, done, overflow;
  logic [W-1:0]  out_d;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  left_shift_sequencer #(.WIDTH(W), .SHAMT_W(SW)) dut (
    .clk(clk), .reset(reset), .start(start), .in(in_d), .amount(amount),
    .mode(mode), .busy(busy), .done(done), .out(out_d), .overflow(overflow)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int clampn(input int a);
    return (a > W) ? W : a;
  endfunction

  function automatic logic [W-1:0] model_out(input logic [W-1:0] a, input int n);
    int v;
    v = int'(a) << n;
    return v[W-1:0];
  endfunction

  // Logical: any 1 among the top n operand bits. Arithmetic: the top n+1 bits of
  // {operand,0} are not all equal, i.e. the sign bit changed at some step.
  function automatic logic model_ovf(input logic [W-1:0] a, input int n, input logic m);
    int t, win, mask;
    if (m) return (n == 0) ? 1'b0 : ((int'(a) >> (W - n)) != 0);
    t    = int'(a) << 1;
    win  = t >> (W - n);
    mask = (1 << (n + 1)) - 1;
    return !((win == 0) || (win == mask));
  endfunction

  task automatic run_op(input logic [W-1:0] a, input int amt, input logic m,
                        input logic [W-1:0] busy_in, input string tag);
    int n, done_at, busy_cnt, done_cnt;
    bit fin;
    n = clampn(amt);
    @(negedge clk);
    start = 1'b1; in_d = a; amount = amt[SW-1:0]; mode = m;
    @(posedge clk); #1;
    in_d = W'($urandom); amount = SW'($urandom); mode = 1'($urandom); start = 1'b0;
    done_at = -1; busy_cnt = 0; done_cnt = 0; fin = 1'b0;
    for (int k = 0; k < 64 && !fin; k++) begin
      if (done) begin done_cnt++; done_at = k; end
      if (busy) begin
        busy_cnt++;
        start = 1'($urandom);
        in_d  = busy_in;
      end else begin
        start = 1'b0;
        fin   = 1'b1;
      end
      if (!fin) begin @(posedge clk); #1; end
    end
    chk({tag, "/finished"}, 32'(fin), 32'd1);
    chk({tag, "/done_cycle"}, 32'(done_at), 32'(n));
    chk({tag, "/done_pulses"}, 32'(done_cnt), 32'd1);
    chk({tag, "/busy_cycles"}, 32'(busy_cnt), 32'(n + 1));
    chk({tag, "/out"}, 32'(out_d), 32'(model_out(a, n)));
    chk({tag, "/ovf"}, 32'(overflow), 32'(model_ovf(a, n, m)));
  endtask

  initial begin
    int dn;
    reset = 1'b1; start = 1'b0; in_d = '0; amount = '0; mode = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst/out", 32'(out_d), 32'd0);
    chk("rst/busy", 32'(busy), 32'd0);
    chk("rst/done", 32'(done), 32'd0);
    chk("rst/ovf", 32'(overflow), 32'd0);
    reset = 1'b0;

    run_op(16'h0001, 4,  1'b1, 16'h0000, "log_1_4");
    run_op(16'h4000, 1,  1'b0, 16'h0000, "ari_4000_1");
    run_op(16'hFFF0, 3,  1'b0, 16'h0000, "ari_fff0_3");
    run_op(16'h8001, 1,  1'b1, 16'h0000, "log_8001_1");
    run_op(16'h1234, 0,  1'b0, 16'h0000, "amt0");
    run_op(16'h00FF, 31, 1'b1, 16'h0000, "clamp31");
    run_op(16'hFFFF, 16, 1'b0, 16'h0000, "ari_full16");
    run_op(16'h0000, 17, 1'b0, 16'h0000, "ari_zero17");
    run_op(16'h0003, 8,  1'b1, 16'hFFFF, "ignore_start");

    // Reset during the third SHIFT cycle of an operation.
    @(negedge clk);
    start = 1'b1; in_d = 16'hC003; amount = 5'd8; mode = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("midrst/out", 32'(out_d), 32'd0);
    chk("midrst/busy", 32'(busy), 32'd0);
    chk("midrst/done", 32'(done), 32'd0);
    chk("midrst/ovf", 32'(overflow), 32'd0);
    dn = 0;
    repeat (20) begin @(posedge clk); #1; if (done || busy) dn++; end
    chk("midrst/quiet", 32'(dn), 32'd0);

    for (int i = 0; i < 40; i++)
      run_op(W'($urandom), int'($urandom_range(0, 31)), 1'($urandom), W'($urandom),
             $sformatf("rnd%0d", i));

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
